// File: rtl/add_pipe_seg.sv
// Segmented carry-pipelined adder/subtractor: DATA_W operands are cut into
// NUM_SEG slices of SEG_W bits and one slice carry is resolved per stage.
module add_pipe_seg #(
    parameter int DATA_W = 64,
    parameter int SEG_W  = 16
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_en,
    input  logic              I_valid,
    input  logic              I_sub,
    input  logic              I_cin,
    input  logic [DATA_W-1:0] I_data_a,
    input  logic [DATA_W-1:0] I_data_b,
    output logic              O_valid,
    output logic              O_sub,
    output logic [DATA_W:0]   O_data_sum,
    output logic              O_ovf
);
    localparam int NUM_SEG = (SEG_W > 0) ? DATA_W / SEG_W : 1;
    localparam int LAST    = NUM_SEG - 1;

    if (SEG_W <= 0) begin : g_bad_seg_w
        $error("add_pipe_seg: SEG_W must be positive");
    end else if ((DATA_W % SEG_W) != 0 || DATA_W < SEG_W) begin : g_bad_data_w
        $error("add_pipe_seg: DATA_W must be a non-zero multiple of SEG_W");
    end

    logic [DATA_W-1:0] b_eff;
    logic              cin_eff;

    assign b_eff   = I_sub ? ~I_data_b : I_data_b;
    assign cin_eff = I_sub | I_cin;

    // x carries resolved sum slices below the current stage and raw A above it;
    // y carries raw B_eff so upper slices can still be added later.
    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        logic [DATA_W-1:0] x_in, y_in, x_d, y_d, x_q, y_q;
        logic              c_in, c_d, c_q;
        logic [SEG_W:0]    seg_sum;

        if (k == 0) begin : g_head
            assign x_in = I_data_a;
            assign y_in = b_eff;
            assign c_in = cin_eff;
        end else begin : g_tail
            assign x_in = g_stage[k-1].x_q;
            assign y_in = g_stage[k-1].y_q;
            assign c_in = g_stage[k-1].c_q;
        end

        always_comb begin
            seg_sum = {1'b0, x_in[k*SEG_W +: SEG_W]} + {1'b0, y_in[k*SEG_W +: SEG_W]}
                    + {{SEG_W{1'b0}}, c_in};
            x_d     = x_in;
            x_d[k*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
            y_d     = y_in;
            c_d     = seg_sum[SEG_W];
        end

        always_ff @(posedge I_clk) begin
            if (I_rst) begin
                x_q <= '0;
                y_q <= '0;
                c_q <= 1'b0;
            end else if (I_en) begin
                x_q <= x_d;
                y_q <= y_d;
                c_q <= c_d;
            end
        end
    end

    // A's MSB is overwritten when the top slice resolves, so keep a copy.
    logic                a_msb_d, a_msb_q;
    logic [NUM_SEG-1:0]  vld_d, vld_q, sub_d, sub_q;

    always_comb begin
        a_msb_d  = g_stage[LAST].x_in[DATA_W-1];
        vld_d    = vld_q << 1;
        vld_d[0] = I_valid;
        sub_d    = sub_q << 1;
        sub_d[0] = I_sub;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            a_msb_q <= 1'b0;
            vld_q   <= '0;
            sub_q   <= '0;
        end else if (I_en) begin
            a_msb_q <= a_msb_d;
            vld_q   <= vld_d;
            sub_q   <= sub_d;
        end
    end

    logic y_unused;
    logic c_out;
    logic b_msb;
    logic s_msb;

    assign y_unused   = ^g_stage[LAST].y_q;
    assign c_out      = g_stage[LAST].c_q;
    assign b_msb      = g_stage[LAST].y_q[DATA_W-1];
    assign s_msb      = g_stage[LAST].x_q[DATA_W-1];

    assign O_valid    = vld_q[LAST];
    assign O_sub      = sub_q[LAST];
    assign O_data_sum = {sub_q[LAST] ? ~c_out : c_out, g_stage[LAST].x_q};
    assign O_ovf      = (a_msb_q == b_msb) && (s_msb != a_msb_q);

endmodule

// File: tb/tb_add_pipe_seg.sv
// Bench for add_pipe_seg: directed corner cases plus random streams checked
// against an arithmetic reference model and a latency queue.
module tb_add_pipe_seg;
    localparam int DW  = 64;
    localparam int SW  = 16;
    localparam int LAT = DW / SW;

    logic          clk;
    logic          I_rst, I_en, I_valid, I_sub, I_cin;
    logic [DW-1:0] I_data_a, I_data_b;
    logic          O_valid, O_sub, O_ovf;
    logic [DW:0]   O_data_sum;

    add_pipe_seg #(.DATA_W(DW), .SEG_W(SW)) dut (
        .I_clk(clk), .I_rst(I_rst), .I_en(I_en), .I_valid(I_valid),
        .I_sub(I_sub), .I_cin(I_cin), .I_data_a(I_data_a), .I_data_b(I_data_b),
        .O_valid(O_valid), .O_sub(O_sub), .O_data_sum(O_data_sum), .O_ovf(O_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        s;
        logic [DW:0] r;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   vecs = 0;
    int   errs = 0;

    function automatic exp_t ref_op(input logic v, input logic s, input logic cin,
                                    input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.v = v;
        e.s = s;
        if (!s) begin
            e.r = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
            e.o = (a[DW-1] == b[DW-1]) && (e.r[DW-1] != a[DW-1]);
        end else begin
            e.r[DW-1:0] = a - b;
            e.r[DW]     = (a < b);
            e.o = (a[DW-1] != b[DW-1]) && (e.r[DW-1] != a[DW-1]);
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] r64();
        logic [DW-1:0] v;
        case ($urandom_range(0, 9))
            0: v = '1;
            1: v = '0;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'h7FFF_FFFF_FFFF_FFFF;
            4: v = 64'h0000_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic ev;
        ev = 1'b0;
        if (q.size() == LAT) ev = q[0].v;
        chk("valid", {{DW{1'b0}}, O_valid}, {{DW{1'b0}}, ev});
        if (ev) begin
            chk("sub_tag", {{DW{1'b0}}, O_sub}, {{DW{1'b0}}, q[0].s});
            chk("sum", O_data_sum, q[0].r);
            chk("ovf", {{DW{1'b0}}, O_ovf}, {{DW{1'b0}}, q[0].o});
        end
    endtask

    task automatic step(input logic en, input logic rst, input logic v, input logic s,
                        input logic cin, input logic [DW-1:0] a, input logic [DW-1:0] b);
        I_en = en; I_rst = rst; I_valid = v; I_sub = s; I_cin = cin;
        I_data_a = a; I_data_b = b;
        @(posedge clk);
        if (rst) q.delete();
        else if (en) begin
            q.push_back(ref_op(v, s, cin, a, b));
            if (q.size() > LAT) void'(q.pop_front());
        end
        #1;
        check_model();
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom), r64(), r64());
    endtask

    task automatic dir(input string tag, input logic s, input logic cin,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW:0] exp_sum, input logic exp_ovf);
        step(1'b1, 1'b0, 1'b1, s, cin, a, b);
        repeat (LAT - 1) idle();
        chk({tag, "_valid"}, {{DW{1'b0}}, O_valid}, 65'd1);
        chk({tag, "_sum"}, O_data_sum, exp_sum);
        chk({tag, "_ovf"}, {{DW{1'b0}}, O_ovf}, {{DW{1'b0}}, exp_ovf});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {{DW{1'b0}}, O_valid}, '0);
        chk({tag, "_sub"}, {{DW{1'b0}}, O_sub}, '0);
        chk({tag, "_sum"}, O_data_sum, '0);
        chk({tag, "_ovf"}, {{DW{1'b0}}, O_ovf}, '0);
    endtask

    initial begin
        // reset state
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '1, '1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '1, '1);
        chk_zero("reset");

        // directed corners
        dir("ripple", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
            65'h1_0000_0000_0000_0000, 1'b0);
        dir("sub_borrow", 1'b1, 1'b0, 64'd5, 64'd7,
            65'h1_FFFF_FFFF_FFFF_FFFE, 1'b0);
        dir("sub_pos", 1'b1, 1'b1, 64'd7, 64'd5,
            65'h0_0000_0000_0000_0002, 1'b0);
        dir("ovf_add", 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
            65'h0_8000_0000_0000_0000, 1'b1);
        dir("ovf_sub", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd1,
            65'h0_7FFF_FFFF_FFFF_FFFF, 1'b1);
        dir("cin_ripple", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
            65'h1_0000_0000_0000_0000, 1'b0);

        // back-to-back stream
        for (int i = 0; i < 1000; i++)
            step(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom), r64(), r64());
        repeat (LAT) idle();

        // stall mid-flight; inputs offered during the stall must be ignored
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom), r64(), r64());
        idle();
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), r64(), r64());
        repeat (LAT) idle();

        // reset with two ops in flight
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom), r64(), r64());
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, r64(), r64());
        chk_zero("mid_rst");
        repeat (LAT + 1) idle();
        dir("post_rst", 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001,
            65'h0_0000_0001_0000_0001, 1'b0);

        // random enable / valid mix
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), 1'b0, 1'($urandom), 1'($urandom),
                 1'($urandom), r64(), r64());
        repeat (LAT) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/add_pipe_seg.md
Name: add_pipe_seg

Overview:
- Parametrised, segmented, carry-pipelined adder/subtractor.
- DATA_W operands are split into NUM_SEG segments of SEG_W bits; exactly one segment carry resolves per stage.
- Adds a valid pipeline, per-operation add/sub mode, carry-in, pipeline stall enable and signed-overflow flag.
- Used wherever wide add/sub must close timing at high clock rate; full throughput, one operation per enabled cycle.

Parameters:
- DATA_W, 64, operand width in bits; must be an integer multiple of SEG_W.
- SEG_W, 16, segment width in bits; one carry-propagate stage per segment.
- NUM_SEG (localparam), DATA_W/SEG_W, number of segments, which is also the pipeline latency in enabled cycles; minimum 1.

Ports:
- I_clk  in  1  clock; all logic on rising edge.
- I_rst  in  1  synchronous reset, active-high.
- I_en  in  1  pipeline advance enable; 0 freezes every stage.
- I_valid  in  1  input operation valid.
- I_sub  in  1  0 = A+B+cin, 1 = A-B (two's complement).
- I_cin  in  1  carry-in for add; ignored when I_sub=1.
- I_data_a  in  DATA_W  operand A.
- I_data_b  in  DATA_W  operand B.
- O_valid  out  1  result valid.
- O_sub  out  1  mode tag aligned with result.
- O_data_sum  out  DATA_W+1  result; bit DATA_W = carry-out (add) or borrow (sub).
- O_ovf  out  1  signed overflow of the DATA_W-bit result.

Behaviour:
- Reset: I_rst=1 at a clock edge clears all valid bits, data registers and mode tags to 0. O_valid, O_sub, O_data_sum and O_ovf read 0 the cycle after. Reset overrides I_en. Operations in flight are discarded; nothing is emitted for them.
- Operand prep at capture:
  - B_eff = I_sub ? ~I_data_b : I_data_b.
  - cin_eff = I_sub ? 1 : I_cin.
- Stage k (1..NUM_SEG):
  - Segment k-1 adds A seg + B_eff seg + incoming carry (cin_eff for segment 0, otherwise the previous segment's registered carry), giving SEG_W+1 bits.
  - Its SEG_W LSBs become final.
  - Segments below k-1 are delayed unchanged.
  - Segments above k-1 are delayed raw, or pre-added without carry, matching the hand-built 4-stage form. Either choice is acceptable if results are bit-exact.
- Latency: the result for an input accepted at enabled edge N appears after NUM_SEG enabled edges. With I_en held at 1, that is exactly NUM_SEG cycles.
- Final carry c_out is the carry out of the top segment.
  - Add: O_data_sum[DATA_W] = c_out.
  - Sub: O_data_sum[DATA_W] = ~c_out, i.e. borrow = 1 iff A<B unsigned.
- O_data_sum[DATA_W-1:0] = (A ± B (+cin)) mod 2^DATA_W.
- O_ovf = (a_msb == beff_msb) && (sum_msb != a_msb), using operand MSBs carried down the pipeline with the data.
- Valid and mode tag: I_valid and I_sub shift through a NUM_SEG-deep pipeline alongside the data, under the same I_en.
  - Data registers advance regardless of valid. When O_valid=0, the O_data_sum contents are don't-care for checking.
- Stall: I_en=0 holds every register, outputs included. Inputs presented during a stall are not captured.
- Throughput: back-to-back valids with I_en=1 give one result per cycle, with no bubbles and no inter-operation carry leakage.
- NUM_SEG=1 degenerates to a single registered full adder with latency 1.
- Elaboration: DATA_W % SEG_W != 0 or SEG_W=0 shall be flagged as an elaboration error.

Test Plan (DATA_W=64, SEG_W=16, latency 4):
- Full carry ripple:
  - Stimulus: A=64'hFFFF_FFFF_FFFF_FFFF, B=1, add, cin=0.
  - Required: 4 cycles later O_valid=1, O_data_sum=65'h1_0000_0000_0000_0000, O_ovf=0.
- Subtract with borrow:
  - Stimulus: A=5, B=7, sub.
  - Required: O_data_sum=65'h1_FFFF_FFFF_FFFF_FFFE (borrow=1).
  - Also: A=7, B=5 sub gives 65'h0_0000_0000_0000_0002.
- Signed overflow:
  - Stimulus: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, add.
  - Required: sum 64'h8000_0000_0000_0000, O_ovf=1, bit64=0.
  - Also: A=64'h8000_0000_0000_0000, B=1, sub gives O_ovf=1.
- Back-to-back stream:
  - Stimulus: 1000 random consecutive ops with mixed I_sub and I_cin.
  - Required: outputs match a reference model in order, one per cycle, O_sub matching each op.
- Stall:
  - Stimulus: issue 3 ops, drop I_en for 5 cycles mid-flight, then restore.
  - Required: outputs frozen during the stall; results correct with latency = 4 enabled edges.
- Reset mid-operation:
  - Stimulus: assert I_rst for 1 cycle while 2 ops are in flight.
  - Required: all outputs 0 on the next cycle, and no stale O_valid afterwards.
  - Then: a new op issued after reset completes correctly 4 cycles later.
